// File: rtl/spi_multi_master_if.sv
// rtl/spi_multi_master_if.sv - request/data/pin bundle between command decoder, SPI master and board pins
interface spi_multi_master_if #(
    parameter int NCH = 3,
    parameter int DW  = 24,
    parameter int LW  = 5
);
    logic [NCH-1:0]    req;
    logic [NCH*LW-1:0] len;
    logic [NCH-1:0]    cpol;
    logic [NCH*DW-1:0] tx;
    logic [NCH-1:0]    miso;
    logic              sclk;
    logic              mosi;
    logic [NCH-1:0]    cs_n;
    logic [NCH-1:0]    ack;
    logic [DW-1:0]     rx;
    logic [NCH-1:0]    busy;

    modport master (
        input  req, len, cpol, tx, miso,
        output sclk, mosi, cs_n, ack, rx, busy
    );

    modport slave (
        output req, len, cpol, tx, miso,
        input  sclk, mosi, cs_n, ack, rx, busy
    );
endinterface

// File: rtl/spi_multi_master.sv
// rtl/spi_multi_master.sv - round-robin SPI master sharing one SCLK/MOSI across NCH chip-selected channels
module spi_multi_master #(
    parameter int NCH      = 3,
    parameter int DW       = 24,
    parameter int LW       = 5,
    parameter int HALF_DIV = 2
) (
    input  logic               clk,
    input  logic               rst,
    spi_multi_master_if.master bus
);
    localparam int CW   = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int DIVW = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;

    typedef enum logic [2:0] {IDLE, GRANT, SETUP, SHIFT, HOLD, DONE} state_t;

    state_t          state, state_nx;
    logic [CW-1:0]   ch, ptr, gnt_ch;
    logic            gnt_found;
    int              arb_idx;
    logic [LW-1:0]   len_raw, len_sel, len_q;
    logic            cpol_q;
    logic [DW-1:0]   tx_q, rx_sh, rx_q;
    logic [DIVW-1:0] div_cnt;
    logic [LW:0]     hp_cnt;
    logic            sclk_q;
    logic            div_end, hp_last;
    logic [NCH-1:0]  cs_n_c, busy_c, ack_c;
    logic            mosi_c;

    assign div_end = (div_cnt == DIVW'(HALF_DIV - 1));
    assign hp_last = (hp_cnt == ({len_q, 1'b0} - (LW+1)'(1)));

    // Search starts one past the last served channel so a held request cannot starve others.
    always_comb begin
        gnt_found = 1'b0;
        gnt_ch    = '0;
        arb_idx   = 0;
        for (int k = 1; k <= NCH; k++) begin
            arb_idx = int'(ptr) + k;
            if (arb_idx >= NCH) arb_idx = arb_idx - NCH;
            if (!gnt_found && bus.req[arb_idx]) begin
                gnt_found = 1'b1;
                gnt_ch    = CW'(arb_idx);
            end
        end
    end

    always_comb begin
        len_raw = bus.len[int'(gnt_ch)*LW +: LW];
        len_sel = len_raw;
        if (len_raw == '0 || int'(len_raw) > DW) len_sel = LW'(DW);
    end

    always_comb begin
        state_nx = state;
        cs_n_c   = '1;
        busy_c   = '0;
        ack_c    = '0;
        mosi_c   = 1'b0;
        case (state)
            IDLE:  if (gnt_found) state_nx = GRANT;
            GRANT: begin
                busy_c[ch] = 1'b1;
                state_nx   = SETUP;
            end
            SETUP, SHIFT, HOLD: begin
                cs_n_c[ch] = 1'b0;
                busy_c[ch] = 1'b1;
                mosi_c     = tx_q[DW-1];
                if (div_end) begin
                    if (state == SETUP)     state_nx = SHIFT;
                    else if (state == HOLD) state_nx = DONE;
                    else if (hp_last)       state_nx = HOLD;
                end
            end
            DONE: begin
                ack_c[ch] = 1'b1;
                state_nx  = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= CW'(NCH - 1);
            ch      <= '0;
            len_q   <= '0;
            cpol_q  <= 1'b0;
            tx_q    <= '0;
            rx_sh   <= '0;
            rx_q    <= '0;
            div_cnt <= '0;
            hp_cnt  <= '0;
            sclk_q  <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: if (gnt_found) begin
                    ch     <= gnt_ch;
                    len_q  <= len_sel;
                    cpol_q <= bus.cpol[gnt_ch];
                    sclk_q <= bus.cpol[gnt_ch];
                    tx_q   <= bus.tx[int'(gnt_ch)*DW +: DW];
                    rx_sh  <= '0;
                end
                GRANT: div_cnt <= '0;
                SETUP: begin
                    if (div_end) begin
                        div_cnt <= '0;
                        hp_cnt  <= '0;
                        sclk_q  <= ~cpol_q;
                        rx_sh   <= {rx_sh[DW-2:0], bus.miso[ch]};
                    end else begin
                        div_cnt <= div_cnt + DIVW'(1);
                    end
                end
                SHIFT: begin
                    if (div_end) begin
                        div_cnt <= '0;
                        // The final half-period already sits at cpol, so no edge is made leaving SHIFT.
                        if (!hp_last) begin
                            hp_cnt <= hp_cnt + (LW+1)'(1);
                            sclk_q <= ~sclk_q;
                            if (hp_cnt[0]) rx_sh <= {rx_sh[DW-2:0], bus.miso[ch]};
                            else           tx_q  <= {tx_q[DW-2:0], 1'b0};
                        end
                    end else begin
                        div_cnt <= div_cnt + DIVW'(1);
                    end
                end
                HOLD: begin
                    if (div_end) begin
                        div_cnt <= '0;
                        rx_q    <= rx_sh;
                    end else begin
                        div_cnt <= div_cnt + DIVW'(1);
                    end
                end
                DONE: begin
                    ptr    <= ch;
                    sclk_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.sclk = sclk_q;
    assign bus.mosi = mosi_c;
    assign bus.cs_n = cs_n_c;
    assign bus.busy = busy_c;
    assign bus.ack  = ack_c;
    assign bus.rx   = rx_q;
endmodule

// File: tb/tb_spi_multi_master.sv
// tb/tb_spi_multi_master.sv - randomized bench for spi_multi_master against a cycle-slot reference model
module tb_spi_multi_master;
    localparam int NCH = 3;
    localparam int DW  = 24;
    localparam int LW  = 5;
    localparam int H   = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spi_multi_master_if #(.NCH(NCH), .DW(DW), .LW(LW)) bus ();

    spi_multi_master #(.NCH(NCH), .DW(DW), .LW(LW), .HALF_DIV(H)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    logic [DW-1:0] resp [NCH];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    task automatic set_ch(input int c, input int l, input logic p, input logic [DW-1:0] t, input logic [DW-1:0] r);
        bus.len[c*LW +: LW] = LW'(l);
        bus.cpol[c]         = p;
        bus.tx[c*DW +: DW]  = t;
        resp[c]             = r;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: the transfer is a fixed frame of cycle slots counted from the granting IDLE cycle.
    bit            armed = 0, act = 0;
    int            i0, ackc, mch, mlen, mptr = NCH - 1;
    logic          mcpol;
    logic [DW-1:0] mtx, mresp, mrx = '0;

    always @(negedge clk) begin
        logic [NCH-1:0] e_cs, e_busy, e_ack, mi;
        logic           e_sclk, e_mosi, care;
        int             d, h, n, l;
        cyc++;
        e_cs = '1; e_busy = '0; e_ack = '0; e_sclk = 1'b0; e_mosi = 1'b0; care = 1'b1;
        mi = NCH'($urandom);
        if (act) begin
            d = cyc - i0;
            n = 0;
            if (cyc < ackc) e_busy[mch] = 1'b1;
            if (d == 1) begin
                e_sclk = mcpol;
            end else if (d <= 1 + H) begin
                e_cs[mch] = 1'b0; e_sclk = mcpol; e_mosi = mtx[DW-1];
            end else if (d <= 1 + H + 2*mlen*H) begin
                h = (d - 2 - H) / H;
                n = h / 2 + 1;
                e_cs[mch] = 1'b0;
                e_sclk = (h % 2 == 0) ? ~mcpol : mcpol;
                if (h < 2*mlen - 1) e_mosi = mtx[DW-1-(h+1)/2];
                else                care = 1'b0;
            end else if (cyc < ackc) begin
                e_cs[mch] = 1'b0; e_sclk = mcpol; care = 1'b0;
            end else begin
                e_sclk = mcpol; e_ack[mch] = 1'b1;
                mrx = mresp & ~({DW{1'b1}} << mlen);
            end
            mi[mch] = (n < mlen) ? mresp[mlen-1-n] : 1'b0;
        end
        if (armed) begin
            check("cs_n", 32'(bus.cs_n), 32'(e_cs));
            check("busy", 32'(bus.busy), 32'(e_busy));
            check("ack",  32'(bus.ack),  32'(e_ack));
            check("sclk", 32'(bus.sclk), 32'(e_sclk));
            check("rx",   32'(bus.rx),   32'(mrx));
            if (care) check("mosi", 32'(bus.mosi), 32'(e_mosi));
        end
        bus.miso = mi;
        if (rst) begin
            armed = 1; act = 0; mptr = NCH - 1; mrx = '0;
        end else if (act) begin
            if (cyc == ackc) begin act = 0; mptr = mch; end
        end else if (bus.req != '0) begin
            for (int k = NCH; k >= 1; k--)
                if (bus.req[(mptr + k) % NCH]) mch = (mptr + k) % NCH;
            l = int'(bus.len[mch*LW +: LW]);
            mlen  = (l == 0 || l > DW) ? DW : l;
            mcpol = bus.cpol[mch];
            mtx   = bus.tx[mch*DW +: DW];
            mresp = resp[mch];
            i0    = cyc;
            ackc  = cyc + 2 + (2*mlen + 2)*H;
            act   = 1;
        end
    end

    initial begin
        bus.req = '0; bus.len = '0; bus.cpol = '0; bus.tx = '0;
        for (int c = 0; c < NCH; c++) resp[c] = '0;
        repeat (3) tick();
        rst = 1'b0;

        set_ch(0, 16, 1'b0, 24'hA5C300, 24'h001234);
        bus.req = 3'b001; tick(); bus.req = '0;
        repeat (80) tick();
        check("t1_rx", 32'(bus.rx), 32'h001234);

        set_ch(1, 8, 1'b1, 24'h3C0000, 24'h00005A);
        bus.req = 3'b010; tick(); bus.req = '0;
        repeat (50) tick();
        check("t2_rx", 32'(bus.rx), 32'h00005A);

        set_ch(2, 0, 1'b0, 24'h5A5A5A, 24'hABCDEF);
        bus.req = 3'b100; tick(); bus.req = '0;
        repeat (110) tick();
        check("t4_len0_rx", 32'(bus.rx), 32'hABCDEF);
        set_ch(2, 31, 1'b1, 24'hC33C96, 24'h13579B);
        bus.req = 3'b100; tick(); bus.req = '0;
        repeat (110) tick();
        check("t4_len31_rx", 32'(bus.rx), 32'h13579B);

        bus.req = 3'b111;
        repeat (400) tick();
        bus.req = '0;
        repeat (110) tick();

        set_ch(0, 24, 1'b0, 24'hF0F0F0, 24'h0F1E2D);
        bus.req = 3'b001; tick();
        bus.req = 3'b101;
        repeat (24) tick();
        rst = 1'b1; tick(); rst = 1'b0;
        repeat (120) tick();
        bus.req = '0;
        repeat (110) tick();

        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < NCH; c++) begin
                set_ch(c, $urandom_range(0, 31), 1'($urandom), DW'($urandom), DW'($urandom));
                bus.req[c] = ($urandom_range(0, 3) == 0);
            end
            rst = ($urandom_range(0, 399) == 0);
            tick();
        end
        rst = 1'b0;
        bus.req = '0;
        repeat (120) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
